mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 81 ++++++++
 tb/tb_mem_port_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter with burst lock sharing one memory port among N_REQ requesters,
// returning read data through a fixed-latency {valid, id} pipeline.
module mem_port_arbiter #(
  parameter int N_REQ        = 4,
  parameter int ADDR_WIDTH   = 11,
  parameter int DATA_WIDTH   = 256,
  parameter int READ_LATENCY = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ-1:0]              wr,
  input  logic [N_REQ-1:0]              lock,
  input  logic [N_REQ*ADDR_WIDTH-1:0]   addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]   wdata,
  output logic [N_REQ-1:0]              gnt,
  output logic [N_REQ-1:0]              rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [ADDR_WIDTH-1:0]         mem_address,
  output logic                          mem_chipselect,
  output logic                          mem_write,
  output logic [DATA_WIDTH-1:0]         mem_writedata,
  output logic [DATA_WIDTH/8-1:0]       mem_byteenable,
  output logic                          mem_clken,
  input  logic [DATA_WIDTH-1:0]         mem_readdata
);
  localparam int IW = $clog2(N_REQ);
  localparam logic [0:0] ARB = 1'b0, OWNED = 1'b1;
  localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};
  logic [0:0] state;
  logic [IW-1:0] owner, rr_ptr, sel;
  logic any;
  logic [READ_LATENCY-1:0] pv;
  logic [IW-1:0] pid [READ_LATENCY];
  // An owner that stops requesting releases the port in the same cycle, so fall through to round-robin.
  always_comb begin
    sel = '0;
    any = 1'b0;
    if (state == OWNED && req[owner]) begin
      sel = owner;
      any = 1'b1;
    end else
      for (int i = N_REQ - 1; i >= 0; i--)
        if (req[(int'(rr_ptr) + i) % N_REQ]) begin
          sel = IW'((int'(rr_ptr) + i) % N_REQ);
          any = 1'b1;
        end
    if (reset) any = 1'b0;
  end
  assign gnt            = any ? ONE << sel : '0;
  assign mem_chipselect = any;
  assign mem_write      = any & wr[sel];
  assign mem_address    = addr[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
  assign mem_writedata  = wdata[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
  assign mem_byteenable = '1;
  assign mem_clken      = 1'b1;
  assign rvalid         = pv[READ_LATENCY-1] ? ONE << pid[READ_LATENCY-1] : '0;
  assign rdata          = mem_readdata;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ARB;
      rr_ptr <= '0;
      owner  <= '0;
      pv     <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pid[i] <= '0;
    end else begin
      if (any) begin
        rr_ptr <= IW'((int'(sel) + 1) % N_REQ);
        state  <= lock[sel] ? OWNED : ARB;
        if (lock[sel]) owner <= sel;
      end else if (state == OWNED && !req[owner])
        state <= ARB;
      pv[0]  <= any & ~wr[sel];
      pid[0] <= sel;
      for (int i = 1; i < READ_LATENCY; i++) begin
        pv[i]  <= pv[i-1];
        pid[i] <= pid[i-1];
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scenario tasks plus a read-return scoreboard against a latency-modelled memory.
module tb_mem_port_arbiter;
  localparam int N = 4, AW = 11, DW = 256, L = 2;
  logic clock = 0, reset = 1;
  logic [N-1:0] req = '0, wr = '0, lock = '0;
  logic [N*AW-1:0] addr = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0] gnt, rvalid;
  logic [DW-1:0] rdata, mem_writedata, mem_readdata;
  logic [AW-1:0] mem_address;
  logic mem_chipselect, mem_write, mem_clken;
  logic [DW/8-1:0] mem_byteenable;
  int n_cmp = 0, n_err = 0, cyc = 0;
  typedef struct { int due; int id; logic [DW-1:0] data; } exp_t;
  exp_t q[$];
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rp [L];
  logic [DW-1:0] pat_ab;

  always #5 clock = ~clock;

  mem_port_arbiter #(.N_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(L)) dut (
    .clock(clock), .reset(reset), .req(req), .wr(wr), .lock(lock), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_address(mem_address),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_byteenable(mem_byteenable), .mem_clken(mem_clken), .mem_readdata(mem_readdata));

  initial for (int i = 0; i < 2**AW; i++) mem[i] <= {8{32'(i) * 32'h9E3779B1}};
  always @(posedge clock) begin
    if (mem_chipselect && mem_write) mem[mem_address] <= mem_writedata;
    rp[0] <= mem[mem_address];
    for (int i = 1; i < L; i++) rp[i] <= rp[i-1];
  end
  assign mem_readdata = rp[L-1];

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset) q.delete();
    else begin
      if (q.size() > 0 && q[0].due == cyc) begin
        n_cmp++;
        if (rvalid !== (N'(1) << q[0].id) || rdata !== q[0].data) begin
          n_err++;
          $display("FAIL rd_return cyc=%0d got rvalid=%b rdata=%h want rvalid=%b rdata=%h",
                   cyc, rvalid, rdata, N'(1) << q[0].id, q[0].data);
        end
        void'(q.pop_front());
      end else if (rvalid !== '0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_rvalid cyc=%0d got rvalid=%b want 0", cyc, rvalid);
      end
      for (int k = 0; k < N; k++)
        if (gnt[k] && req[k] && !wr[k]) q.push_back('{cyc + L, k, mem[addr[k*AW +: AW]]});
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1; req = '0; lock = '0; wr = '0;
    repeat (2) tick;
    reset = 0;
  endtask

  task automatic drain;
    req = '0; lock = '0; wr = '0;
    repeat (L + 2) tick;
  endtask

  task automatic test_reset;
    reset = 1; req = '1; wr = '1;
    tick;
    @(negedge clock);
    n_cmp++; if (gnt !== '0) begin n_err++; $display("FAIL reset_gnt got %b want 0", gnt); end
    n_cmp++; if (rvalid !== '0) begin n_err++; $display("FAIL reset_rvalid got %b want 0", rvalid); end
    n_cmp++; if (mem_chipselect !== 1'b0) begin n_err++; $display("FAIL reset_cs got %b want 0", mem_chipselect); end
    n_cmp++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL reset_write got %b want 0", mem_write); end
    n_cmp++; if (mem_clken !== 1'b1) begin n_err++; $display("FAIL reset_clken got %b want 1", mem_clken); end
    n_cmp++; if (mem_byteenable !== '1) begin n_err++; $display("FAIL reset_be got %h want all ones", mem_byteenable); end
    req = '0; wr = '0;
    tick;
    reset = 0;
    tick;
  endtask

  task automatic test_single_read;
    addr[2*AW +: AW] = 11'h010;
    req = 4'b0100;
    @(negedge clock);
    n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL single_gnt got %b want 0100", gnt); end
    n_cmp++; if (mem_address !== 11'h010) begin n_err++; $display("FAIL single_addr got %h want 010", mem_address); end
    n_cmp++; if (mem_chipselect !== 1'b1 || mem_write !== 1'b0) begin
      n_err++; $display("FAIL single_cs_we got cs=%b we=%b want cs=1 we=0", mem_chipselect, mem_write); end
    tick;
    req = '0;
  endtask

  task automatic test_round_robin;
    for (int k = 0; k < N; k++) addr[k*AW +: AW] = AW'(11'h100 + k * 3);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      n_cmp++;
      if (gnt !== (N'(1) << (i % N))) begin
        n_err++; $display("FAIL rr_order step=%0d got %b want %b", i, gnt, N'(1) << (i % N)); end
      tick;
    end
    req = '0;
  endtask

  task automatic test_lock;
    logic [N-1:0] t_req [6] = '{4'b0010, 4'b1011, 4'b1011, 4'b1011, 4'b1001, 4'b0001};
    logic [N-1:0] t_lck [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
    logic [N-1:0] t_gnt [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0001};
    for (int i = 0; i < 6; i++) begin
      req = t_req[i]; lock = t_lck[i];
      @(negedge clock);
      n_cmp++;
      if (gnt !== t_gnt[i]) begin n_err++; $display("FAIL lock_gnt step=%0d got %b want %b", i, gnt, t_gnt[i]); end
      tick;
    end
    req = '0; lock = '0;
  endtask

  task automatic test_owner_drop;
    logic [N-1:0] t_req [3] = '{4'b0010, 4'b1001, 4'b0001};
    logic [N-1:0] t_lck [3] = '{4'b0010, 4'b0000, 4'b0000};
    logic [N-1:0] t_gnt [3] = '{4'b0010, 4'b1000, 4'b0001};
    for (int i = 0; i < 3; i++) begin
      req = t_req[i]; lock = t_lck[i];
      @(negedge clock);
      n_cmp++;
      if (gnt !== t_gnt[i]) begin n_err++; $display("FAIL drop_gnt step=%0d got %b want %b", i, gnt, t_gnt[i]); end
      tick;
    end
    req = '0; lock = '0;
  endtask

  task automatic test_mixed;
    pat_ab = {32{8'hAB}};
    addr[0*AW +: AW] = 11'h005; wdata[0 +: DW] = pat_ab; wr = 4'b0001; req = 4'b0001;
    @(negedge clock);
    n_cmp++; if (gnt !== 4'b0001 || mem_write !== 1'b1) begin
      n_err++; $display("FAIL mixed_wr got gnt=%b we=%b want gnt=0001 we=1", gnt, mem_write); end
    n_cmp++; if (mem_address !== 11'h005 || mem_writedata !== pat_ab) begin
      n_err++; $display("FAIL mixed_wr_port got addr=%h data=%h want 005 / AB..", mem_address, mem_writedata); end
    tick;
    addr[3*AW +: AW] = 11'h005; wr = '0; req = 4'b1000;
    @(negedge clock);
    n_cmp++; if (gnt !== 4'b1000 || mem_write !== 1'b0) begin
      n_err++; $display("FAIL mixed_rd got gnt=%b we=%b want gnt=1000 we=0", gnt, mem_write); end
    tick;
    req = '0;
    @(negedge clock);
    n_cmp++; if (mem_chipselect !== 1'b0 || mem_write !== 1'b0) begin
      n_err++; $display("FAIL mixed_idle got cs=%b we=%b want 0/0", mem_chipselect, mem_write); end
    repeat (L - 1) tick;
    @(negedge clock);
    n_cmp++; if (rvalid !== 4'b1000 || rdata !== pat_ab) begin
      n_err++; $display("FAIL mixed_return got rvalid=%b rdata=%h want 1000 / AB..", rvalid, rdata); end
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] t_req [5] = '{4'b0100, 4'b0001, 4'b1000, 4'b0010, 4'b0010};
    for (int k = 0; k < N; k++) addr[k*AW +: AW] = AW'(11'h2A0 + k * 5);
    for (int i = 0; i < 5; i++) begin
      req = t_req[i];
      @(negedge clock);
      n_cmp++;
      if (gnt !== t_req[i]) begin n_err++; $display("FAIL b2b_gnt step=%0d got %b want %b", i, gnt, t_req[i]); end
      tick;
    end
    req = '0;
  endtask

  task automatic test_reset_mid_read;
    addr[2*AW +: AW] = 11'h020; req = 4'b0100;
    @(negedge clock);
    n_cmp++; if (gnt !== 4'b0100) begin n_err++; $display("FAIL midrst_gnt got %b want 0100", gnt); end
    tick;
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      n_cmp++; if (gnt !== '0 || rvalid !== '0 || mem_chipselect !== 1'b0) begin
        n_err++; $display("FAIL midrst_hold step=%0d got gnt=%b rvalid=%b cs=%b want 0", i, gnt, rvalid, mem_chipselect); end
      tick;
    end
    req = '0; reset = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      n_cmp++; if (rvalid !== '0) begin n_err++; $display("FAIL midrst_after step=%0d got rvalid=%b want 0", i, rvalid); end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_single_read;   drain;
    do_reset; test_round_robin;  drain;
    do_reset; test_lock;         drain;
    do_reset; test_owner_drop;   drain;
    do_reset; test_mixed;        drain;
    do_reset; test_back_to_back; drain;
    test_reset_mid_read; drain;
    n_cmp++;
    if (q.size() != 0) begin n_err++; $display("FAIL pending_reads got %0d want 0", q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
